// File: rtl/bsg_mem_1r1w_sync_mask_write_bit_driver.sv
// Initiator for a 1r1w sync-read, bit-masked-write RAM: zero/init sweep after reset, then
// valid/ready write and read requests mapped onto RAM port cycles with a held read-data output.
module bsg_mem_1r1w_sync_mask_write_bit_driver #(
    parameter int                 width_p                = 8,
    parameter int                 els_p                  = 16,
    parameter int                 read_write_same_addr_p = 0,
    parameter logic [width_p-1:0] init_val_p             = '0,
    parameter int                 addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    output logic                     init_done_o,
    output logic                     err_o,
    input  logic                     w_v_i,
    input  logic [width_p-1:0]       w_mask_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    output logic                     w_ready_o,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic                     r_ready_o,
    output logic                     r_data_v_o,
    output logic [width_p-1:0]       r_data_o,
    input  logic                     r_data_yumi_i,
    output logic                     mem_w_v_o,
    output logic [width_p-1:0]       mem_w_mask_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // One extra bit so els_p itself is representable when els_p is a power of two.
    localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);
    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam bit                       rwsa_lp      = (read_write_same_addr_p != 0);

    state_e                     state_q, state_d;
    logic [addr_width_lp-1:0]   cnt_q, cnt_d;
    logic                       init_done_q, init_done_d;
    logic                       err_q, err_d;
    logic                       rd_pending_q, rd_pending_d;
    logic                       rd_oor_q, rd_oor_d;
    logic                       hold_v_q, hold_v_d;
    logic [width_p-1:0]         hold_data_q, hold_data_d;

    logic                       is_run;
    logic                       w_oor, r_oor;
    logic                       out_free, conflict;
    logic                       w_accept, r_accept;
    logic [width_p-1:0]         rd_data_raw;

    assign is_run      = (state_q == ST_RUN);
    assign w_oor       = ({1'b0, w_addr_i} >= els_lp);
    assign r_oor       = ({1'b0, r_addr_i} >= els_lp);
    assign out_free    = ~r_data_v_o | r_data_yumi_i;
    assign conflict    = ~rwsa_lp & w_v_i & r_v_i & (w_addr_i == r_addr_i);

    assign w_ready_o   = is_run;
    assign r_ready_o   = is_run & out_free & ~conflict;
    assign w_accept    = w_v_i & w_ready_o;
    assign r_accept    = r_v_i & r_ready_o;

    assign init_done_o = init_done_q;
    assign err_o       = err_q;

    // Out-of-range reads never touch the RAM and return zeros on the normal schedule.
    assign rd_data_raw = rd_oor_q ? '0 : mem_r_data_i;
    assign r_data_v_o  = rd_pending_q | hold_v_q;
    assign r_data_o    = hold_v_q ? hold_data_q : rd_data_raw;

    assign mem_r_v_o    = r_accept & ~r_oor;
    assign mem_r_addr_o = r_addr_i;

    always_comb begin
        mem_w_v_o    = w_accept & ~w_oor;
        mem_w_mask_o = w_mask_i;
        mem_w_addr_o = w_addr_i;
        mem_w_data_o = w_data_i;
        if (!is_run) begin
            // Gated by reset so the sweep write is not presented while reset is held.
            mem_w_v_o    = reset_n_i;
            mem_w_mask_o = '1;
            mem_w_addr_o = cnt_q;
            mem_w_data_o = init_val_p;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_done_d  = init_done_q;
        err_d        = err_q | (w_accept & w_oor) | (r_accept & r_oor);
        rd_pending_d = r_accept;
        rd_oor_d     = r_accept & r_oor;
        hold_v_d     = hold_v_q;
        hold_data_d  = hold_data_q;

        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + addr_width_lp'(1);
            if (cnt_q == last_addr_lp) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
                cnt_d       = '0;
            end
        end

        // Fresh RAM data not taken this cycle is parked in the hold register until yumi.
        if (r_data_yumi_i) begin
            hold_v_d = 1'b0;
        end else if (rd_pending_q) begin
            hold_v_d    = 1'b1;
            hold_data_d = rd_data_raw;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
            rd_pending_q <= 1'b0;
            rd_oor_q     <= 1'b0;
            hold_v_q     <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_d;
            err_q        <= err_d;
            rd_pending_q <= rd_pending_d;
            rd_oor_q     <= rd_oor_d;
            hold_v_q     <= hold_v_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_bit_driver.sv
// Self-checking bench: randomized and directed requests against a word-array reference model,
// with a behavioural sync-read mask-write RAM attached to the driver's memory ports.
module tb_bsg_mem_1r1w_sync_mask_write_bit_driver;

    localparam int             W    = 8;
    localparam int             ELS  = 48;
    localparam int             AW   = 6;
    localparam int             RWSA = 0;
    localparam logic [W-1:0]   INIT = 8'h3C;

    logic          clk, reset_n;
    logic          init_done_o, err_o;
    logic          w_v_i;
    logic [W-1:0]  w_mask_i, w_data_i;
    logic [AW-1:0] w_addr_i;
    logic          w_ready_o;
    logic          r_v_i;
    logic [AW-1:0] r_addr_i;
    logic          r_ready_o, r_data_v_o;
    logic [W-1:0]  r_data_o;
    logic          r_data_yumi_i;
    logic          mem_w_v_o;
    logic [W-1:0]  mem_w_mask_o, mem_w_data_o;
    logic [AW-1:0] mem_w_addr_o;
    logic          mem_r_v_o;
    logic [AW-1:0] mem_r_addr_o;
    logic [W-1:0]  mem_r_data_i;

    int errors = 0;
    int checks = 0;

    bsg_mem_1r1w_sync_mask_write_bit_driver #(
        .width_p(W), .els_p(ELS), .read_write_same_addr_p(RWSA), .init_val_p(INIT)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .init_done_o(init_done_o), .err_o(err_o),
        .w_v_i(w_v_i), .w_mask_i(w_mask_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .w_ready_o(w_ready_o),
        .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_ready_o(r_ready_o),
        .r_data_v_o(r_data_v_o), .r_data_o(r_data_o), .r_data_yumi_i(r_data_yumi_i),
        .mem_w_v_o(mem_w_v_o), .mem_w_mask_o(mem_w_mask_o), .mem_w_addr_o(mem_w_addr_o),
        .mem_w_data_o(mem_w_data_o),
        .mem_r_v_o(mem_r_v_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_data_i(mem_r_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; read data is noise on cycles without a read so stale use is visible.
    logic [W-1:0] ram [ELS];
    always @(posedge clk) begin
        if (mem_w_v_o)
            ram[mem_w_addr_o] <= (ram[mem_w_addr_o] & ~mem_w_mask_o) | (mem_w_data_o & mem_w_mask_o);
        if (mem_r_v_o) mem_r_data_i <= ram[mem_r_addr_o];
        else           mem_r_data_i <= W'($urandom);
    end

    // Reference model: word contents, cycles since reset, one-slot output, sticky error.
    logic [W-1:0] m_mem [ELS];
    int           m_k;
    bit           m_out_v;
    logic [W-1:0] m_out_d;
    bit           m_err;

    task automatic model_reset();
        m_k = 0; m_out_v = 0; m_out_d = '0; m_err = 0;
        for (int i = 0; i < ELS; i++) m_mem[i] = INIT;
    endtask

    // Drives one cycle (entered at posedge+1), compares every output mid-cycle, advances the model.
    task automatic run_cycle(input bit wv, input logic [W-1:0] wm, input logic [AW-1:0] wa,
                             input logic [W-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                             input bit yumi);
        bit run, conflict, wacc, racc, w_in, r_in, ye, exp_mwv, exp_mrv;
        logic [W-1:0] rd_val;
        ye = yumi && m_out_v;
        w_v_i = wv; w_mask_i = wm; w_addr_i = wa; w_data_i = wd;
        r_v_i = rv; r_addr_i = ra; r_data_yumi_i = ye;
        @(negedge clk);
        run      = (m_k >= ELS);
        conflict = (RWSA == 0) && wv && rv && (wa == ra);
        wacc     = run && wv;
        racc     = run && rv && (!m_out_v || ye) && !conflict;
        w_in     = (int'(wa) < ELS);
        r_in     = (int'(ra) < ELS);
        exp_mwv  = run ? (wacc && w_in) : 1'b1;
        exp_mrv  = racc && r_in;

        checks++;
        if (init_done_o !== run) begin
            errors++; $display("FAIL init_done: got %b expected %b (k=%0d)", init_done_o, run, m_k);
        end
        checks++;
        if (w_ready_o !== run) begin
            errors++; $display("FAIL w_ready: got %b expected %b (k=%0d)", w_ready_o, run, m_k);
        end
        checks++;
        if (r_ready_o !== racc && rv) begin
            errors++; $display("FAIL r_ready: got %b expected %b (k=%0d)", r_ready_o, racc, m_k);
        end
        checks++;
        if (r_data_v_o !== m_out_v) begin
            errors++; $display("FAIL r_data_v: got %b expected %b (k=%0d)", r_data_v_o, m_out_v, m_k);
        end
        if (m_out_v) begin
            checks++;
            if (r_data_o !== m_out_d) begin
                errors++; $display("FAIL r_data: got %h expected %h (k=%0d)", r_data_o, m_out_d, m_k);
            end
        end
        checks++;
        if (err_o !== m_err) begin
            errors++; $display("FAIL err: got %b expected %b (k=%0d)", err_o, m_err, m_k);
        end
        checks++;
        if (mem_w_v_o !== exp_mwv) begin
            errors++; $display("FAIL mem_w_v: got %b expected %b (k=%0d)", mem_w_v_o, exp_mwv, m_k);
        end else if (exp_mwv) begin
            checks++;
            if (run ? ({mem_w_addr_o, mem_w_mask_o, mem_w_data_o} !== {wa, wm, wd})
                    : ({mem_w_addr_o, mem_w_mask_o, mem_w_data_o} !== {AW'(m_k), {W{1'b1}}, INIT})) begin
                errors++;
                $display("FAIL mem_w_port: got addr=%h mask=%h data=%h (k=%0d run=%b)",
                         mem_w_addr_o, mem_w_mask_o, mem_w_data_o, m_k, run);
            end
        end
        checks++;
        if (mem_r_v_o !== exp_mrv) begin
            errors++; $display("FAIL mem_r_v: got %b expected %b (k=%0d)", mem_r_v_o, exp_mrv, m_k);
        end else if (exp_mrv) begin
            checks++;
            if (mem_r_addr_o !== ra) begin
                errors++; $display("FAIL mem_r_addr: got %h expected %h", mem_r_addr_o, ra);
            end
        end

        rd_val = r_in ? m_mem[ra] : '0;
        if (wacc && w_in) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
        if ((wacc && !w_in) || (racc && !r_in)) m_err = 1;
        if (racc) begin
            m_out_v = 1; m_out_d = rd_val;
        end else if (ye) begin
            m_out_v = 0;
        end
        if (m_k < 1000000) m_k++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, '0, '0, '0, 0, '0, 0);
    endtask

    task automatic take(); run_cycle(0, '0, '0, '0, 0, '0, 1); endtask

    task automatic test_reset();
        reset_n = 1'b0;
        w_v_i = 1; w_mask_i = '1; w_addr_i = '0; w_data_i = '0;
        r_v_i = 1; r_addr_i = '0; r_data_yumi_i = 0;
        #3;
        checks++;
        if ({init_done_o, err_o, r_data_v_o, mem_w_v_o, mem_r_v_o, w_ready_o, r_ready_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {init_done_o, err_o, r_data_v_o, mem_w_v_o, mem_r_v_o, w_ready_o, r_ready_o});
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_init();
        idle(ELS + 1);
        checks++;
        if (init_done_o !== 1'b1 || mem_w_v_o !== 1'b0) begin
            errors++; $display("FAIL init_done_after_sweep: got done=%b wv=%b expected 1,0", init_done_o, mem_w_v_o);
        end
    endtask

    task automatic test_read_after_init();
        run_cycle(0, '0, '0, '0, 1, 6'd10, 0);
        checks++;
        if (r_data_v_o !== 1'b1 || r_data_o !== INIT) begin
            errors++; $display("FAIL read_init_val: got v=%b data=%h expected 1,%h", r_data_v_o, r_data_o, INIT);
        end
        take();
    endtask

    task automatic test_mask_write();
        run_cycle(1, 8'h0F, 6'd5, 8'hFF, 0, '0, 0);
        run_cycle(0, '0, '0, '0, 1, 6'd5, 0);
        checks++;
        if (r_data_o !== 8'h3F) begin
            errors++; $display("FAIL mask_write: got %h expected 3f", r_data_o);
        end
        take();
    endtask

    task automatic test_conflict();
        run_cycle(1, 8'hFF, 6'd7, 8'h5A, 1, 6'd7, 0);
        checks++;
        if (r_data_v_o !== 1'b0) begin
            errors++; $display("FAIL conflict_stall: got r_data_v=%b expected 0", r_data_v_o);
        end
        run_cycle(0, '0, '0, '0, 1, 6'd7, 0);
        checks++;
        if (r_data_o !== 8'h5A) begin
            errors++; $display("FAIL conflict_new_data: got %h expected 5a", r_data_o);
        end
        take();
    endtask

    task automatic test_hold();
        run_cycle(0, '0, '0, '0, 1, 6'd3, 0);
        for (int i = 0; i < 4; i++) begin
            // Writes to the address just read must not disturb the returned word.
            run_cycle(1, '1, 6'd3, W'($urandom), 1, AW'($urandom_range(0, ELS - 1)), 0);
            checks++;
            if (r_data_v_o !== 1'b1 || r_data_o !== INIT) begin
                errors++; $display("FAIL hold_stable: got v=%b data=%h expected 1,%h", r_data_v_o, r_data_o, INIT);
            end
        end
        take();
    endtask

    task automatic test_oor();
        run_cycle(1, '1, AW'(ELS), 8'hFF, 0, '0, 0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL err_set: got %b expected 1", err_o);
        end
        idle(3);
        run_cycle(0, '0, '0, '0, 1, AW'(ELS + 1), 0);
        checks++;
        if (r_data_v_o !== 1'b1 || r_data_o !== 8'h00 || err_o !== 1'b1) begin
            errors++; $display("FAIL oor_read: got v=%b data=%h err=%b expected 1,00,1", r_data_v_o, r_data_o, err_o);
        end
        take();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_cycle(($urandom & 1) != 0, W'($urandom), AW'($urandom_range(0, ELS - 1)), W'($urandom),
                      1, AW'($urandom_range(ELS - 8, ELS - 1)), 1);
        end
        for (int i = 0; i < 12; i++) begin
            run_cycle(0, '0, '0, '0, 1, AW'(i), 1);
            checks++;
            if (r_data_v_o !== 1'b1) begin
                errors++; $display("FAIL back_to_back_valid: got %b expected 1 (i=%0d)", r_data_v_o, i);
            end
        end
        take();
    endtask

    task automatic test_random();
        logic [AW-1:0] wa, ra;
        for (int i = 0; i < 400; i++) begin
            wa = (($urandom & 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, ELS + 3));
            ra = (($urandom & 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, ELS + 3));
            run_cycle(($urandom_range(0, 2) != 0), W'($urandom), wa, W'($urandom),
                      ($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 2) != 0));
        end
        take();
    endtask

    task automatic test_reset_mid();
        run_cycle(0, '0, '0, '0, 1, 6'd2, 0);
        checks++;
        if (r_data_v_o !== 1'b1) begin
            errors++; $display("FAIL pre_reset_valid: got %b expected 1", r_data_v_o);
        end
        w_v_i = 0; r_v_i = 0; r_data_yumi_i = 0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (r_data_v_o !== 1'b0 || mem_w_v_o !== 1'b0 || init_done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b wv=%b done=%b err=%b expected 0,0,0,0",
                     r_data_v_o, mem_w_v_o, init_done_o, err_o);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        idle(3);
        checks++;
        if (mem_w_v_o !== 1'b1 || mem_w_addr_o !== 6'd3) begin
            errors++; $display("FAIL reinit_sweep: got v=%b addr=%0d expected 1,3", mem_w_v_o, mem_w_addr_o);
        end
        idle(ELS);
        test_read_after_init();
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_after_init();
        test_mask_write();
        test_conflict();
        test_hold();
        test_oor();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
